// File: rtl/cam_lkup_ctrl.sv
// cam_lkup_ctrl: request-side controller for a CAM.
// Accepts one write or search request at a time, drives the CAM write or
// search port, waits up to TMO_CYC cycles for a search hit, and returns
// one response per request.
// Optional feature: define CAM_LKUP_STATS_EN to add saturating hit/miss
// counters with a synchronous clear input.
module cam_lkup_ctrl #(
    parameter int CAM_DW  = 32,
    parameter int CAM_AW  = 8,
    parameter int TMO_CYC = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_op,
    input  logic [CAM_AW-1:0] req_addr,
    input  logic [CAM_DW-1:0] req_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_op,
    output logic              rsp_hit,
    output logic              rsp_tmo,
    output logic [CAM_AW-1:0] rsp_addr,
    output logic [CAM_DW-1:0] rsp_data,
    output logic              cam_wr_valid,
    output logic [CAM_AW-1:0] cam_wr_addr,
    output logic [CAM_DW-1:0] cam_wr_data,
    output logic              cam_srch_valid,
    output logic [CAM_DW-1:0] cam_srch_key,
    input  logic              cam_hit,
    input  logic [CAM_AW-1:0] cam_hit_addr,
    input  logic [CAM_DW-1:0] cam_hit_data
`ifdef CAM_LKUP_STATS_EN
    ,
    input  logic              stat_clr,
    output logic [15:0]       stat_hit_cnt,
    output logic [15:0]       stat_miss_cnt
`endif
);

    localparam int TMO_W = $clog2(TMO_CYC + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        SRCH = 2'd2,
        RSP  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [TMO_W-1:0]   r_cnt;
    logic [TMO_W-1:0]   w_cnt_nxt;
    logic               r_op;
    logic               w_op_nxt;
    logic [CAM_AW-1:0]  r_addr;
    logic [CAM_AW-1:0]  w_addr_nxt;
    logic [CAM_DW-1:0]  r_data;
    logic [CAM_DW-1:0]  w_data_nxt;
    logic               r_wr_valid;
    logic               w_wr_valid_nxt;
    logic               r_srch_valid;
    logic               w_srch_valid_nxt;
    logic               r_rsp_valid;
    logic               w_rsp_valid_nxt;
    logic               r_rsp_hit;
    logic               w_rsp_hit_nxt;
    logic               r_rsp_tmo;
    logic               w_rsp_tmo_nxt;
    logic [CAM_AW-1:0]  r_rsp_addr;
    logic [CAM_AW-1:0]  w_rsp_addr_nxt;
    logic [CAM_DW-1:0]  r_rsp_data;
    logic [CAM_DW-1:0]  w_rsp_data_nxt;
    logic               w_last;

    // Counter value seen on the final search cycle before giving up.
    assign w_last = (r_cnt == TMO_W'(TMO_CYC - 1));

    // State and registered outputs; reset discards any in-flight request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_op         <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
            r_wr_valid   <= 1'b0;
            r_srch_valid <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_hit    <= 1'b0;
            r_rsp_tmo    <= 1'b0;
            r_rsp_addr   <= '0;
            r_rsp_data   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_op         <= w_op_nxt;
            r_addr       <= w_addr_nxt;
            r_data       <= w_data_nxt;
            r_wr_valid   <= w_wr_valid_nxt;
            r_srch_valid <= w_srch_valid_nxt;
            r_rsp_valid  <= w_rsp_valid_nxt;
            r_rsp_hit    <= w_rsp_hit_nxt;
            r_rsp_tmo    <= w_rsp_tmo_nxt;
            r_rsp_addr   <= w_rsp_addr_nxt;
            r_rsp_data   <= w_rsp_data_nxt;
        end
    end

    // Next-state and next-output decode; response fields hold unless loaded.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_op_nxt         = r_op;
        w_addr_nxt       = r_addr;
        w_data_nxt       = r_data;
        w_wr_valid_nxt   = 1'b0;
        w_srch_valid_nxt = 1'b0;
        w_rsp_valid_nxt  = r_rsp_valid;
        w_rsp_hit_nxt    = r_rsp_hit;
        w_rsp_tmo_nxt    = r_rsp_tmo;
        w_rsp_addr_nxt   = r_rsp_addr;
        w_rsp_data_nxt   = r_rsp_data;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_op_nxt   = req_op;
                    w_addr_nxt = req_addr;
                    w_data_nxt = req_data;
                    if (req_op) begin
                        w_state_nxt      = SRCH;
                        w_cnt_nxt        = '0;
                        w_srch_valid_nxt = 1'b1;
                    end else begin
                        w_state_nxt    = WR;
                        w_wr_valid_nxt = 1'b1;
                    end
                end
            end
            WR: begin
                w_state_nxt     = RSP;
                w_rsp_valid_nxt = 1'b1;
                w_rsp_hit_nxt   = 1'b0;
                w_rsp_tmo_nxt   = 1'b0;
                w_rsp_addr_nxt  = r_addr;
                w_rsp_data_nxt  = r_data;
            end
            SRCH: begin
                w_cnt_nxt = r_cnt + TMO_W'(1);
                // A hit on the last cycle still counts as a hit.
                if (cam_hit) begin
                    w_state_nxt     = RSP;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_hit_nxt   = 1'b1;
                    w_rsp_tmo_nxt   = 1'b0;
                    w_rsp_addr_nxt  = cam_hit_addr;
                    w_rsp_data_nxt  = cam_hit_data;
                end else if (w_last) begin
                    w_state_nxt     = RSP;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_hit_nxt   = 1'b0;
                    w_rsp_tmo_nxt   = 1'b1;
                    w_rsp_addr_nxt  = '0;
                    w_rsp_data_nxt  = '0;
                end else begin
                    w_srch_valid_nxt = 1'b1;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    w_state_nxt     = IDLE;
                    w_rsp_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign req_ready      = (r_state == IDLE);
    assign rsp_valid      = r_rsp_valid;
    assign rsp_op         = r_op;
    assign rsp_hit        = r_rsp_hit;
    assign rsp_tmo        = r_rsp_tmo;
    assign rsp_addr       = r_rsp_addr;
    assign rsp_data       = r_rsp_data;
    assign cam_wr_valid   = r_wr_valid;
    assign cam_wr_addr    = r_addr;
    assign cam_wr_data    = r_data;
    assign cam_srch_valid = r_srch_valid;
    assign cam_srch_key   = r_data;

`ifdef CAM_LKUP_STATS_EN
    logic [15:0] r_hit_cnt;
    logic [15:0] r_miss_cnt;
    logic        w_hit_evt;
    logic        w_tmo_evt;

    assign w_hit_evt = (r_state == SRCH) && cam_hit;
    assign w_tmo_evt = (r_state == SRCH) && !cam_hit && w_last;

    // Saturating hit/miss counters; clear takes priority over an increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (stat_clr) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_hit_evt && (r_hit_cnt != 16'hFFFF))
                r_hit_cnt <= r_hit_cnt + 16'd1;
            if (w_tmo_evt && (r_miss_cnt != 16'hFFFF))
                r_miss_cnt <= r_miss_cnt + 16'd1;
        end
    end

    assign stat_hit_cnt  = r_hit_cnt;
    assign stat_miss_cnt = r_miss_cnt;
`endif

endmodule

// File: tb/tb_cam_lkup_ctrl.sv
// Self-checking bench for cam_lkup_ctrl: directed scenarios plus random
// write/search traffic, checked against a transaction-level reference model
// (a CAM contents array and per-request expected response/latency).
module tb_cam_lkup_ctrl;
    localparam int DW  = 32;
    localparam int AW  = 8;
    localparam int TMO = 20;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready, req_op;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_data;
    logic          rsp_valid, rsp_ready, rsp_op, rsp_hit, rsp_tmo;
    logic [AW-1:0] rsp_addr;
    logic [DW-1:0] rsp_data;
    logic          cam_wr_valid;
    logic [AW-1:0] cam_wr_addr;
    logic [DW-1:0] cam_wr_data;
    logic          cam_srch_valid;
    logic [DW-1:0] cam_srch_key;
    logic          cam_hit;
    logic [AW-1:0] cam_hit_addr;
    logic [DW-1:0] cam_hit_data;
`ifdef CAM_LKUP_STATS_EN
    logic          stat_clr;
    logic [15:0]   stat_hit_cnt, stat_miss_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int n_txn    = 0;

    // Reference model state
    logic [DW-1:0] mdl_mem [256];
    int            mdl_addrs[$];
    int            mdl_hits = 0;
    int            mdl_miss = 0;

    always #5 clk = ~clk;

    cam_lkup_ctrl #(.CAM_DW(DW), .CAM_AW(AW), .TMO_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op),
        .rsp_hit(rsp_hit), .rsp_tmo(rsp_tmo), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
        .cam_wr_valid(cam_wr_valid), .cam_wr_addr(cam_wr_addr), .cam_wr_data(cam_wr_data),
        .cam_srch_valid(cam_srch_valid), .cam_srch_key(cam_srch_key),
        .cam_hit(cam_hit), .cam_hit_addr(cam_hit_addr), .cam_hit_data(cam_hit_data)
`ifdef CAM_LKUP_STATS_EN
        , .stat_clr(stat_clr), .stat_hit_cnt(stat_hit_cnt), .stat_miss_cnt(stat_miss_cnt)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One full request/response transaction. d = cycle (1-based, after accept)
    // at which the CAM reports a hit for a search; 0 = never.
    task automatic do_req(input logic op, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input int d, input logic [AW-1:0] haddr, input logic [DW-1:0] hdata,
                          input int bp);
        logic          exp_hit, exp_tmo, key_ok, stable;
        int            exp_lat, lat, srch_cnt, wr_cnt;
        logic [AW-1:0] exp_addr, s_addr;
        logic [DW-1:0] exp_data, s_data;
        logic          s_op, s_hit, s_tmo;
        logic          stray;

        exp_hit  = op && (d >= 1) && (d <= TMO);
        exp_tmo  = op && !exp_hit;
        exp_lat  = !op ? 1 : (exp_hit ? d : TMO);
        exp_addr = !op ? addr : (exp_hit ? haddr : '0);
        exp_data = !op ? data : (exp_hit ? hdata : '0);

        check("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_data = data;
        @(posedge clk); #1;
        req_valid = 1'b0; req_op = 1'($urandom); req_addr = AW'($urandom); req_data = $urandom;

        srch_cnt = 0; wr_cnt = 0; key_ok = 1'b1; lat = 0;
        stray = 1'($urandom);
        if (!op) begin
            check("wr_addr", cam_wr_addr, addr);
            check("wr_data", cam_wr_data, data);
        end
        if (cam_srch_valid) srch_cnt++;
        if (cam_wr_valid) wr_cnt++;
        if (cam_srch_valid && cam_srch_key !== data) key_ok = 1'b0;

        for (int k = 1; k <= 60 && lat == 0; k++) begin
            if (op) begin
                cam_hit = (k == d); cam_hit_addr = haddr; cam_hit_data = hdata;
            end else begin
                cam_hit = stray && (k == 1); cam_hit_addr = AW'($urandom); cam_hit_data = $urandom;
            end
            @(posedge clk); #1;
            cam_hit = 1'b0;
            if (rsp_valid) lat = k;
            if (cam_srch_valid) srch_cnt++;
            if (cam_wr_valid) wr_cnt++;
            if (cam_srch_valid && cam_srch_key !== data) key_ok = 1'b0;
        end

        check("latency", lat, exp_lat);
        if (lat == 0) return;
        check("srch_valid_cycles", srch_cnt, op ? exp_lat : 0);
        check("wr_valid_cycles", wr_cnt, op ? 0 : 1);
        check("srch_key_stable", key_ok, 1);
        check("rsp_op", rsp_op, op);
        check("rsp_hit", rsp_hit, exp_hit);
        check("rsp_tmo", rsp_tmo, exp_tmo);
        check("rsp_addr", rsp_addr, exp_addr);
        check("rsp_data", rsp_data, exp_data);
        check("req_ready_busy", req_ready, 0);

        s_op = rsp_op; s_hit = rsp_hit; s_tmo = rsp_tmo; s_addr = rsp_addr; s_data = rsp_data;
        stable = 1'b1;
        for (int i = 0; i < bp; i++) begin
            rsp_ready = 1'b0;
            req_valid = 1'($urandom); req_op = 1'b1;
            cam_hit = 1'($urandom); cam_hit_addr = AW'($urandom); cam_hit_data = $urandom;
            @(posedge clk); #1;
            cam_hit = 1'b0;
            if (!rsp_valid || req_ready || rsp_op !== s_op || rsp_hit !== s_hit ||
                rsp_tmo !== s_tmo || rsp_addr !== s_addr || rsp_data !== s_data)
                stable = 1'b0;
        end
        if (bp > 0) check("bp_stable", stable, 1);

        // Handshake cycle, with a request already waiting: it must not be
        // taken on the handshake edge itself.
        rsp_ready = 1'b1; req_valid = 1'b1; req_op = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0; req_valid = 1'b0;
        check("rsp_valid_after_hs", rsp_valid, 0);
        check("req_ready_after_hs", req_ready, 1);
        check("no_accept_on_hs", cam_srch_valid, 0);

        if (!op) begin
            mdl_mem[addr] = data;
            mdl_addrs.push_back(int'(addr));
        end
        if (exp_hit) mdl_hits++;
        if (exp_tmo) mdl_miss++;
        n_txn++;
        $display("txn %0d op=%0d addr=%0h data=%0h hit=%0d tmo=%0d lat=%0d bp=%0d",
                 n_txn, op, rsp_addr, rsp_data, rsp_hit, rsp_tmo, lat, bp);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_op = 1'b0; req_addr = '0; req_data = '0;
        rsp_ready = 1'b0; cam_hit = 1'b0; cam_hit_addr = '0; cam_hit_data = '0;
`ifdef CAM_LKUP_STATS_EN
        stat_clr = 1'b0;
`endif
        @(posedge clk); #1;
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_wr_valid", cam_wr_valid, 0);
        check("rst_srch_valid", cam_srch_valid, 0);
        check("rst_rsp_fields", {rsp_op, rsp_hit, rsp_tmo, rsp_addr}, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_srch_key", cam_srch_key, 0);
        check("rst_wr_data", cam_wr_data, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
`ifdef CAM_LKUP_STATS_EN
        check("rst_stat_hit", stat_hit_cnt, 0);
        check("rst_stat_miss", stat_miss_cnt, 0);
`endif

        // Directed scenarios
        do_req(1'b0, 8'h01, 32'hFFFF_FFFF, 0, '0, '0, 0);
        do_req(1'b1, 8'h00, 32'hFFFF_FFFF, 3, 8'h01, 32'hFFFF_FFFF, 0);
        do_req(1'b1, 8'h00, 32'h1234_5678, 0, '0, '0, 0);
`ifdef CAM_LKUP_STATS_EN
        check("stat_hit_1", stat_hit_cnt, 1);
        check("stat_miss_1", stat_miss_cnt, 1);
`endif
        do_req(1'b1, 8'h00, 32'hFFFF_FFFF, TMO, 8'h01, 32'hFFFF_FFFF, 0);
        do_req(1'b0, 8'h7E, 32'hA5A5_0F0F, 0, '0, '0, 5);

        // Random traffic
        for (int t = 0; t < 40; t++) begin
            logic          op;
            logic [AW-1:0] a;
            logic [DW-1:0] dat;
            int            d;
            op = 1'($urandom);
            a = AW'($urandom);
            dat = $urandom;
            d = 0;
            if (op && mdl_addrs.size() > 0 && ($urandom_range(0, 3) != 0)) begin
                a = AW'(mdl_addrs[$urandom_range(0, mdl_addrs.size() - 1)]);
                dat = mdl_mem[a];
                d = $urandom_range(1, TMO + 4);
            end
            do_req(op, a, dat, d, a, dat, $urandom_range(0, 3));
        end

`ifdef CAM_LKUP_STATS_EN
        check("stat_hit_model", stat_hit_cnt, 16'(mdl_hits));
        check("stat_miss_model", stat_miss_cnt, 16'(mdl_miss));
        stat_clr = 1'b1;
        @(posedge clk); #1;
        stat_clr = 1'b0;
        check("stat_clr_hit", stat_hit_cnt, 0);
        check("stat_clr_miss", stat_miss_cnt, 0);
`endif

        // Reset in the middle of a search
        req_valid = 1'b1; req_op = 1'b1; req_addr = '0; req_data = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        check("pre_rst_srch_valid", cam_srch_valid, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_srch_valid", cam_srch_valid, 0);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_req_ready", req_ready, 1);
`ifdef CAM_LKUP_STATS_EN
        check("mid_rst_stat_hit", stat_hit_cnt, 0);
        check("mid_rst_stat_miss", stat_miss_cnt, 0);
`endif
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        begin
            int seen;
            seen = 0;
            rsp_ready = 1'b1;
            for (int i = 0; i < TMO + 10; i++) begin
                @(posedge clk); #1;
                if (rsp_valid || cam_srch_valid) seen++;
            end
            rsp_ready = 1'b0;
            check("no_rsp_after_rst", seen, 0);
            check("req_ready_after_rst", req_ready, 1);
        end

        // Controller still usable after reset
        do_req(1'b0, 8'h33, 32'h0BAD_F00D, 0, '0, '0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Guard against a hung run
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
